// File: rtl/riscv_ic_pkg.sv
// riscv_ic_pkg: types and constants shared by the interrupt controller files.
//   state_e      controller FSM state (IDLE, SERVICE)
//   MCAUSE_BASE  mcause value for external line 0
//   MAX_IRQ      largest supported number of external lines
//   mcause_of()  mcause value for a given line index
package riscv_ic_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  localparam logic [31:0] MCAUSE_BASE = 32'h8000_0010;
  localparam int          MAX_IRQ     = 16;

  function automatic logic [31:0] mcause_of(input logic [3:0] idx);
    return MCAUSE_BASE + {28'd0, idx};
  endfunction

endpackage

// File: rtl/riscv_int_ctrl_if.sv
// riscv_int_ctrl_if: core/peripheral side signals of the interrupt controller.
//   int_req_i  [NUM_IRQ]  interrupt requests from peripherals
//   mie_i      [32]       enable mask from the core
//   int_rst_i  [1]        end-of-service strobe (mret)
//   int_o      [1]        interrupt request to the core
//   mcause_o   [32]       cause of the interrupt in service
//   int_fin_o  [NUM_IRQ]  one-hot service-complete pulse
// Modports: master = core/peripheral side, slave = controller.
interface riscv_int_ctrl_if
  import riscv_ic_pkg::*;
#(
  parameter int NUM_IRQ = MAX_IRQ
);

  logic [NUM_IRQ-1:0] int_req_i;
  logic [31:0]        mie_i;
  logic               int_rst_i;
  logic               int_o;
  logic [31:0]        mcause_o;
  logic [NUM_IRQ-1:0] int_fin_o;

  modport master (
    output int_req_i, mie_i, int_rst_i,
    input  int_o, mcause_o, int_fin_o
  );

  modport slave (
    input  int_req_i, mie_i, int_rst_i,
    output int_o, mcause_o, int_fin_o
  );

endinterface

// File: rtl/riscv_ic_prio_enc.sv
// riscv_ic_prio_enc: combinational fixed-priority encoder, lowest index wins.
//   req    [NUM_IRQ]  request vector
//   valid  [1]        any request set
//   idx    [4]        index of the lowest set bit (0 when none)
module riscv_ic_prio_enc
  import riscv_ic_pkg::*;
#(
  parameter int NUM_IRQ = MAX_IRQ
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [3:0]         idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/riscv_int_ctrl.sv
// riscv_int_ctrl: single-level, non-nesting external interrupt controller.
//   clk  rising-edge clock shared with the core
//   rst  synchronous active-high reset
//   bus  riscv_int_ctrl_if.slave (requests, mask, mret strobe, int_o,
//        mcause_o, int_fin_o)
// Build option: define RISCV_IC_EDGE_EN to capture requests on rising edges
// instead of levels.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an eligible (pending & enabled) line
// SERVICE | winner latched, int_o pulsed on first cycle, waiting for mret
module riscv_int_ctrl
  import riscv_ic_pkg::*;
#(
  parameter int NUM_IRQ = MAX_IRQ
) (
  input logic             clk,
  input logic             rst,
  riscv_int_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] captured;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [NUM_IRQ-1:0] fin_mask;
  logic [NUM_IRQ-1:0] fin_q;
  logic [3:0]         winner_q;
  logic [3:0]         enc_idx;
  logic               enc_valid;
  logic               enter;
  logic               done;
  logic               first_q;
  logic               rearm_q;
  logic [31:0]        mcause_q;
  logic               unused_mie;

  assign unused_mie = ^bus.mie_i[31:NUM_IRQ];

`ifdef RISCV_IC_EDGE_EN
  logic [NUM_IRQ-1:0] int_req_q;

  always_ff @(posedge clk) begin
    if (rst) int_req_q <= '0;
    else     int_req_q <= bus.int_req_i;
  end

  assign captured = bus.int_req_i & ~int_req_q;
`else
  assign captured = bus.int_req_i;
`endif

  assign eligible = pending_q & bus.mie_i[NUM_IRQ-1:0];

  riscv_ic_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign enter = (state_q == IDLE) && enc_valid;
  assign done  = (state_q == SERVICE) && bus.int_rst_i;

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) win_onehot[i] = (winner_q == 4'(i));
  end

  assign fin_mask = done ? win_onehot : '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enc_valid)     state_d = SERVICE;
      SERVICE: if (bus.int_rst_i) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath registers. The winner's pending bit stays set through service,
  // so a fresh capture on that line while in service would be absorbed by
  // the clear at completion; rearm_q remembers it and re-pends the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      winner_q  <= '0;
      mcause_q  <= '0;
      first_q   <= 1'b0;
      rearm_q   <= 1'b0;
      fin_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~fin_mask) | captured
                   | (rearm_q ? fin_mask : '0);
      first_q   <= enter;
      fin_q     <= fin_mask;
      if (enter || done)
        rearm_q <= 1'b0;
      else if (state_q == SERVICE && |(captured & win_onehot))
        rearm_q <= 1'b1;
      if (enter) begin
        winner_q <= enc_idx;
        mcause_q <= mcause_of(enc_idx);
      end
    end
  end

  // Outputs
  always_comb begin
    bus.int_o     = (state_q == SERVICE) && first_q;
    bus.mcause_o  = mcause_q;
    bus.int_fin_o = fin_q;
  end

endmodule

// File: tb/tb_riscv_int_ctrl.sv
module tb_riscv_int_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  riscv_int_ctrl_if #(.NUM_IRQ(16)) bus ();

  riscv_int_ctrl #(.NUM_IRQ(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] req;
    logic [31:0] mie;
    logic        ir;
    logic        exp_int;
    logic [31:0] exp_mc;
    logic [15:0] exp_fin;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic e_int, input logic [31:0] e_mc,
                            input logic [15:0] e_fin);
    check({name, ".int_o"}, {31'd0, bus.int_o}, {31'd0, e_int});
    check({name, ".mcause_o"}, bus.mcause_o, e_mc);
    check({name, ".int_fin_o"}, {16'd0, bus.int_fin_o}, {16'd0, e_fin});
  endtask

  int n_int, n_fin;

  initial begin
    //            req       mie        ir  int mcause        fin
    // single request on line 3
    vecs[0]  = '{16'h0008, 32'h0000_0008, 1'b0, 1'b0, 32'h0,          16'h0};
    vecs[1]  = '{16'h0000, 32'h0000_0008, 1'b0, 1'b1, 32'h8000_0013, 16'h0};
    vecs[2]  = '{16'h0000, 32'h0000_0008, 1'b0, 1'b0, 32'h8000_0013, 16'h0};
    vecs[3]  = '{16'h0000, 32'h0000_0008, 1'b1, 1'b0, 32'h8000_0013, 16'h0008};
    vecs[4]  = '{16'h0000, 32'h0000_0008, 1'b0, 1'b0, 32'h8000_0013, 16'h0};
    // spurious mret in IDLE
    vecs[5]  = '{16'h0000, 32'h0000_0008, 1'b1, 1'b0, 32'h8000_0013, 16'h0};
    vecs[6]  = '{16'h0000, 32'h0000_0008, 1'b0, 1'b0, 32'h8000_0013, 16'h0};
    // lines 5 and 2 together: 2 first, 5 after one IDLE cycle
    vecs[7]  = '{16'h0024, 32'h0000_0024, 1'b0, 1'b0, 32'h8000_0013, 16'h0};
    vecs[8]  = '{16'h0000, 32'h0000_0024, 1'b0, 1'b1, 32'h8000_0012, 16'h0};
    vecs[9]  = '{16'h0000, 32'h0000_0024, 1'b0, 1'b0, 32'h8000_0012, 16'h0};
    vecs[10] = '{16'h0000, 32'h0000_0024, 1'b1, 1'b0, 32'h8000_0012, 16'h0004};
    vecs[11] = '{16'h0000, 32'h0000_0024, 1'b0, 1'b1, 32'h8000_0015, 16'h0};
    vecs[12] = '{16'h0000, 32'h0000_0024, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[13] = '{16'h0000, 32'h0000_0024, 1'b1, 1'b0, 32'h8000_0015, 16'h0020};
    vecs[14] = '{16'h0000, 32'h0000_0024, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    // masked line 7, then enabled; mask cleared during service
    vecs[15] = '{16'h0080, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[16] = '{16'h0000, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[17] = '{16'h0000, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[18] = '{16'h0000, 32'h0000_0080, 1'b0, 1'b1, 32'h8000_0017, 16'h0};
    vecs[19] = '{16'h0000, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0017, 16'h0};
    vecs[20] = '{16'h0000, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0017, 16'h0080};
    vecs[21] = '{16'h0000, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0017, 16'h0};

    bus.int_req_i = '0;
    bus.mie_i     = '0;
    bus.int_rst_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_outs("reset", 1'b0, 32'h0, 16'h0);
    rst = 1'b0;
    tick();
    check_outs("post_reset", 1'b0, 32'h0, 16'h0);

    for (int i = 0; i < NV; i++) begin
      bus.int_req_i = vecs[i].req;
      bus.mie_i     = vecs[i].mie;
      bus.int_rst_i = vecs[i].ir;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_int, vecs[i].exp_mc, vecs[i].exp_fin);
    end

    // Reset while serving line 1, with mret on the same edge.
    bus.mie_i = 32'h2;
    bus.int_req_i = 16'h0002;
    tick();
    bus.int_req_i = '0;
    tick();
    check_outs("svc_line1", 1'b1, 32'h8000_0011, 16'h0);
    rst = 1'b1;
    bus.int_rst_i = 1'b1;
    tick();
    check_outs("rst_mid_svc", 1'b0, 32'h0, 16'h0);
    rst = 1'b0;
    bus.int_rst_i = 1'b0;
    n_int = 0;
    n_fin = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.int_o) n_int++;
      if (bus.int_fin_o != '0) n_fin++;
    end
    check("rst_pending_empty.int", n_int, 0);
    check("rst_no_fin", n_fin, 0);

    bus.mie_i = 32'h1;
`ifdef RISCV_IC_EDGE_EN
    // Line 0 held high for 10 cycles: one service only.
    n_int = 0;
    n_fin = 0;
    bus.int_req_i = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      bus.int_rst_i = (i == 3);
      tick();
      if (bus.int_o) n_int++;
      if (bus.int_fin_o == 16'h0001) n_fin++;
    end
    bus.int_rst_i = 1'b0;
    check("edge_hold.int_count", n_int, 1);
    check("edge_hold.fin_count", n_fin, 1);
    // Low-high toggle during service gives a second service.
    bus.int_req_i = '0;
    tick();
    bus.int_req_i = 16'h0001;
    tick();
    tick();
    check_outs("edge_svc1", 1'b1, 32'h8000_0010, 16'h0);
    bus.int_req_i = '0;
    tick();
    bus.int_req_i = 16'h0001;
    tick();
    bus.int_rst_i = 1'b1;
    tick();
    check_outs("edge_fin1", 1'b0, 32'h8000_0010, 16'h0001);
    bus.int_rst_i = 1'b0;
    tick();
    check_outs("edge_svc2", 1'b1, 32'h8000_0010, 16'h0);
`else
    // Level mode: a line still held at completion is serviced again.
    bus.int_req_i = 16'h0001;
    tick();
    tick();
    check_outs("lvl_svc1", 1'b1, 32'h8000_0010, 16'h0);
    bus.int_rst_i = 1'b1;
    tick();
    check_outs("lvl_fin1", 1'b0, 32'h8000_0010, 16'h0001);
    bus.int_rst_i = 1'b0;
    tick();
    check_outs("lvl_svc2", 1'b1, 32'h8000_0010, 16'h0);
    bus.int_req_i = '0;
`endif
    bus.int_req_i = '0;
    bus.int_rst_i = 1'b1;
    tick();
    check_outs("final_fin", 1'b0, 32'h8000_0010, 16'h0001);
    bus.int_rst_i = 1'b0;
    tick();
    tick();
    check_outs("final_idle", 1'b0, 32'h8000_0010, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_int_ctrl.md
RISCV_INT_CTRL -- requirements
Module: riscv_int_ctrl

Interface
REQ-001 Parameter: NUM_IRQ, 16, number of external interrupt lines, legal range 1..16.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-003 clk  input  1  rising-edge clock shared with the core.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 int_req_i  input  NUM_IRQ  interrupt requests from peripherals.
REQ-006 mie_i  input  32  enable mask from the core; bit k enables line k for k < NUM_IRQ; bits k >= NUM_IRQ are ignored.
REQ-007 int_rst_i  input  1  end-of-service strobe from the core, asserted on mret.
REQ-008 int_o  output  1  interrupt request to the core.
REQ-009 mcause_o  output  32  cause of the interrupt currently in service.
REQ-010 int_fin_o  output  NUM_IRQ  one-hot service-complete pulse to the peripherals.

Function
REQ-011 The block SHALL keep a NUM_IRQ-bit pending register.
- Each cycle: pending |= captured requests (see Configuration).
- pending[k] SHALL clear only on completion of line k.
REQ-012 Eligible lines SHALL be pending & mie_i[NUM_IRQ-1:0].
REQ-013 States SHALL be IDLE and SERVICE.
REQ-014 IDLE -> SERVICE when any line is eligible.
- Winner = lowest eligible index.
- The winner index SHALL be registered.
- mcause_o SHALL be registered as 32'h8000_0010 + index.
REQ-015 int_o SHALL be high for exactly the first cycle in SERVICE and low at all other times.
- Latency: line eligible at edge N -> int_o high after edge N+1.
- The core samples int_o in that cycle.
REQ-016 In SERVICE, mcause_o and the winner index SHALL remain stable.
- New requests SHALL be captured into pending but not serviced.
- No nesting.
REQ-017 SERVICE -> IDLE on int_rst_i.
- On that same edge: int_fin_o[winner] is high for exactly one cycle and pending[winner] clears.
- mcause_o holds its last value until the next entry to SERVICE.
REQ-018 Clearing mie_i during SERVICE SHALL NOT abort service.
REQ-019 int_rst_i asserted in IDLE SHALL be ignored: no int_fin_o pulse, no state change.
REQ-020 After return to IDLE, the earliest next int_o SHALL come one cycle after the IDLE cycle that sees an eligible line; there is no back-to-back entry without an IDLE cycle.
REQ-021 A request on the winner line arriving in the same cycle as int_rst_i SHALL:
- be captured again in edge mode;
- remain asserted in level mode.

Reset
REQ-022 On rst the block SHALL go to IDLE and clear pending, the winner index and the edge-detect history.
REQ-023 During and after reset, outputs SHALL be int_o=0, int_fin_o=0 and mcause_o=0.
REQ-024 Reset SHALL take priority over all other events, including mid-SERVICE; no int_fin_o pulse is emitted for aborted service.

Configuration
REQ-025 Macro RISCV_IC_EDGE_EN, when defined:
- captured requests = int_req_i & ~int_req_q, where int_req_q is int_req_i registered one cycle;
- a held-high line raises pending once per rising edge.
REQ-026 When RISCV_IC_EDGE_EN is undefined:
- captured requests = int_req_i (level mode);
- no history register is synthesized;
- peripherals must deassert int_req_i on int_fin_o.

Structure
REQ-027 Package riscv_ic_pkg SHALL hold:
- the state enum (IDLE, SERVICE);
- MCAUSE_BASE = 32'h8000_0010;
- the maximum line count, 16.
REQ-028 The priority selection SHALL be a sub-module riscv_ic_prio_enc:
- combinational;
- NUM_IRQ-bit input -> valid flag plus 4-bit index.

Verification
REQ-029 Single request: line 3 pulsed with mie_i=32'h8 -> int_o one-cycle pulse one edge later, mcause_o=32'h8000_0013; int_rst_i -> int_fin_o=16'h0008 for one cycle.
REQ-030 Simultaneous requests: lines 5 and 2, mask 32'h24 -> line 2 serviced first (mcause 32'h8000_0012); after int_rst_i and one IDLE cycle -> line 5 serviced (mcause 32'h8000_0015).
REQ-031 Masked request: line 7 with mie_i=0 -> no int_o; later mie_i=32'h80 -> int_o after one edge, mcause 32'h8000_0017.
REQ-032 Reset mid-SERVICE: rst while serving line 1 -> outputs zero; no int_fin_o pulse; pending empty.
REQ-033 Edge mode: line 0 held high for 10 cycles -> exactly one service; low-high toggle during SERVICE -> second service after completion.
REQ-034 Spurious int_rst_i while in IDLE -> int_fin_o stays 0 and state stays IDLE.
